seven_scanner: RTL



---
 rtl/seven_pkg.sv | 18 +
 rtl/seven_scanner_if.sv | 27 ++
 rtl/seven_scanner.sv | 92 +++++++++
 3 files changed

// File: rtl/seven_pkg.sv
// Shared types and constants for the seven-segment display path.
// Used by both the segment generator and the scanner.
package seven_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  typedef seg_t [NUM_DIGITS-1:0] seg_bank_t;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [2:0] idx);
    anode_sel = ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_scanner_if.sv
// Segment-generator to scanner connection: per-digit patterns in, anode/cathode drive out.
interface seven_scanner_if;
  import seven_pkg::*;

  logic                  enable;
  seg_bank_t             segments;
  logic [NUM_DIGITS-1:0] an;
  seg_t                  ca;
  logic                  frame_tick;

  modport master (
    output enable,
    output segments,
    input  an,
    input  ca,
    input  frame_tick
  );

  modport slave (
    input  enable,
    input  segments,
    output an,
    output ca,
    output frame_tick
  );

endinterface

// File: rtl/seven_scanner.sv
// Time-multiplexed 8-digit common-anode scanner with per-slot blanking and
// a once-per-frame snapshot of the segment patterns.
module seven_scanner
  import seven_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input logic            clk,
  input logic            reset,
  seven_scanner_if.slave bus
);

  localparam int            CW       = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

  if (DIGIT_CYCLES < 2) begin : g_chk_digit
    $error("seven_scanner: DIGIT_CYCLES must be at least 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_chk_blank
    $error("seven_scanner: BLANK_CYCLES must be in 0..DIGIT_CYCLES-1");
  end

  logic [CW-1:0]         cnt, cnt_nxt;
  logic [2:0]            idx, idx_nxt;
  seg_bank_t             snap, snap_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  seg_t                  ca_nxt;
  logic                  ft_nxt;
  logic                  slot_end;
  logic                  frame_wrap;
  logic                  blank;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == 3'd7);

  // With no blanking the compare would be constant, so drop it entirely.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (cnt < CW'(BLANK_CYCLES));
  end

  always_comb begin
    cnt_nxt  = cnt;
    idx_nxt  = idx;
    snap_nxt = snap;
    an_nxt   = '1;
    ca_nxt   = SEG_OFF;
    ft_nxt   = 1'b0;
    if (!bus.enable) begin
      cnt_nxt  = '0;
      idx_nxt  = '0;
      snap_nxt = bus.segments;
    end else begin
      if (slot_end) begin
        cnt_nxt = '0;
        idx_nxt = idx + 3'd1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      // Snapshot only at the frame boundary so a frame never tears.
      if (frame_wrap) begin
        snap_nxt = bus.segments;
        ft_nxt   = 1'b1;
      end
      if (!blank) begin
        an_nxt = anode_sel(idx);
        ca_nxt = snap[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      idx            <= '0;
      snap           <= {NUM_DIGITS{SEG_OFF}};
      bus.an         <= '1;
      bus.ca         <= SEG_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      idx            <= idx_nxt;
      snap           <= snap_nxt;
      bus.an         <= an_nxt;
      bus.ca         <= ca_nxt;
      bus.frame_tick <= ft_nxt;
    end
  end

endmodule
